// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, FSM states, read-select codes.
// Optional madd/maddu/msub/msubu support is enabled by defining MDU_MADD_EN.
package mdu_ctrl_pkg;

  localparam int OP_W   = 4;
  localparam int DATA_W = 32;

  typedef enum logic [OP_W-1:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam logic RD_SEL_LO = 1'b0;
  localparam logic RD_SEL_HI = 1'b1;

  // Multiply-class ops share MULT_LAT; accumulate variants only exist with MDU_MADD_EN.
  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: r = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_long_op(input logic [OP_W-1:0] op);
    return is_mul_op(op) || is_div_op(op);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage <-> MDU signal bundle. start/op/a/b are qualified only by start (no ready: the
// D-stage must honour stall, so a start that arrives while busy is simply dropped).
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;

  logic                start;
  logic [OP_W-1:0]     op;
  logic [DATA_W-1:0]   a;
  logic [DATA_W-1:0]   b;
  logic                use_md;
  logic                rd_sel;
  logic                busy;
  logic                stall;
  logic [DATA_W-1:0]   rd;
  mdu_state_e          dbg_state;

  modport master (
    output start, op, a, b, use_md, rd_sel,
    input  busy, stall, rd, dbg_state
  );

  modport slave (
    input  start, op, a, b, use_md, rd_sel,
    output busy, stall, rd, dbg_state
  );

endinterface

// File: rtl/mdu_arith.sv
// Combinational datapath: 64-bit {HI,LO} result for the latched op/operands.
// Accumulate ops (MDU_MADD_EN) add/subtract the product from the current {HI,LO}.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] lo,
  output logic [63:0]       result,
  output logic              wr_en
);

  logic [63:0] ax_s;
  logic [63:0] bx_s;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic signed [DATA_W-1:0] sa;
  logic signed [DATA_W-1:0] sb;
  logic signed [DATA_W-1:0] quo_s;
  logic signed [DATA_W-1:0] rem_s;

  // The low 64 bits of a product of sign-extended operands equal the signed product.
  assign ax_s   = {{32{a[31]}}, a};
  assign bx_s   = {{32{b[31]}}, b};
  assign prod_s = ax_s * bx_s;
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign sa     = a;
  assign sb     = b;

  always_comb begin
    result = {hi, lo};
    wr_en  = 1'b0;
    quo_s  = '0;
    rem_s  = '0;
    case (op)
      OP_MULT: begin
        result = prod_s;
        wr_en  = 1'b1;
      end
      OP_MULTU: begin
        result = prod_u;
        wr_en  = 1'b1;
      end
      OP_DIV: begin
        if (b != '0) begin
          quo_s  = sa / sb;
          rem_s  = sa % sb;
          result = {rem_s, quo_s};
          wr_en  = 1'b1;
        end
      end
      OP_DIVU: begin
        if (b != '0) begin
          result = {a % b, a / b};
          wr_en  = 1'b1;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        result = {hi, lo} + prod_s;
        wr_en  = 1'b1;
      end
      OP_MADDU: begin
        result = {hi, lo} + prod_u;
        wr_en  = 1'b1;
      end
      OP_MSUB: begin
        result = {hi, lo} - prod_s;
        wr_en  = 1'b1;
      end
      OP_MSUBU: begin
        result = {hi, lo} - prod_u;
        wr_en  = 1'b1;
      end
`endif
      default: begin
        result = {hi, lo};
        wr_en  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: countdown FSM, pending operand registers, HI/LO and D-stage stall request.
// Build with MDU_MADD_EN defined to add madd/maddu/msub/msubu.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  bus
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  mdu_state_e        state;
  mdu_state_e        state_nxt;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  logic [OP_W-1:0]   pend_op;
  logic [DATA_W-1:0] pend_a;
  logic [DATA_W-1:0] pend_b;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [63:0]       arith_result;
  logic              arith_wr_en;
  logic              issue;
  logic              finish;
  logic              move_hi;
  logic              move_lo;

  assign issue   = (state == ST_IDLE) && bus.start && is_long_op(bus.op);
  assign finish  = (state == ST_BUSY) && (count == CW'(1));
  assign move_hi = (state == ST_IDLE) && bus.start && (bus.op == OP_MTHI);
  assign move_lo = (state == ST_IDLE) && bus.start && (bus.op == OP_MTLO);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      ST_IDLE: begin
        if (issue) begin
          state_nxt = ST_BUSY;
          count_nxt = is_mul_op(bus.op) ? CW'(MULT_LAT) : CW'(DIV_LAT);
        end
      end
      ST_BUSY: begin
        if (finish) begin
          state_nxt = ST_IDLE;
          count_nxt = '0;
        end else begin
          count_nxt = count - CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Operands are captured once at issue so forwarding changes mid-operation cannot disturb them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_op <= '0;
      pend_a  <= '0;
      pend_b  <= '0;
    end else if (issue) begin
      pend_op <= bus.op;
      pend_a  <= bus.a;
      pend_b  <= bus.b;
    end
  end

  mdu_arith u_arith (
    .op     (pend_op),
    .a      (pend_a),
    .b      (pend_b),
    .hi     (hi),
    .lo     (lo),
    .result (arith_result),
    .wr_en  (arith_wr_en)
  );

  // Divide-by-zero leaves arith_wr_en low, so HI/LO survive the full busy period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (finish) begin
      if (arith_wr_en) begin
        hi <= arith_result[63:32];
        lo <= arith_result[31:0];
      end
    end else begin
      if (move_hi) hi <= bus.a;
      if (move_lo) lo <= bus.a;
    end
  end

  assign bus.busy      = (state == ST_BUSY);
  assign bus.stall     = bus.use_md && (bus.busy || (bus.start && is_long_op(bus.op)));
  assign bus.rd        = (bus.rd_sel == RD_SEL_HI) ? hi : lo;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vectors, stall behaviour, reset abort,
// random mult/div traffic; expected {HI,LO} go through a scoreboard queue.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int MLAT = 5;
  localparam int DLAT = 10;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [63:0] exp_q[$];
  logic [63:0] m_hl;

  mdu_ctrl_if bus ();

  mdu_ctrl #(.MULT_LAT(MLAT), .DIV_LAT(DLAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input logic [3:0] o);
    int l;
    l = 0;
    if (o == OP_MULT || o == OP_MULTU) l = MLAT;
    if (o == OP_DIV || o == OP_DIVU) l = DLAT;
`ifdef MDU_MADD_EN
    if (o == OP_MADD || o == OP_MADDU || o == OP_MSUB || o == OP_MSUBU) l = MLAT;
`endif
    return l;
  endfunction

  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] hl);
    longint      sp;
    logic [63:0] up;
    int          q;
    int          r;
    logic [63:0] res;
    sp  = longint'($signed(x)) * longint'($signed(y));
    up  = {32'd0, x} * {32'd0, y};
    res = hl;
    case (o)
      OP_MULT:  res = sp;
      OP_MULTU: res = up;
      OP_DIV: begin
        if (y != 0) begin
          q   = int'(x) / int'(y);
          r   = int'(x) % int'(y);
          res = {r, q};
        end
      end
      OP_DIVU:  if (y != 0) res = {x % y, x / y};
      OP_MTHI:  res = {x, hl[31:0]};
      OP_MTLO:  res = {hl[63:32], x};
`ifdef MDU_MADD_EN
      OP_MADD:  res = hl + sp;
      OP_MADDU: res = hl + up;
      OP_MSUB:  res = hl - sp;
      OP_MSUBU: res = hl - up;
`endif
      default:  res = hl;
    endcase
    return res;
  endfunction

  // driver tasks: every task starts and ends just after a falling edge
  task automatic drive_issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic check_regs(input string name);
    logic [63:0] e;
    logic [31:0] got_hi;
    logic [31:0] got_lo;
    bus.rd_sel = RD_SEL_HI;
    #1;
    got_hi = bus.rd;
    bus.rd_sel = RD_SEL_LO;
    #1;
    got_lo = bus.rd;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: queue empty, got hi=%h lo=%h", name, got_hi, got_lo);
    end else begin
      e = exp_q.pop_front();
      if (got_hi !== e[63:32]) begin
        errors++;
        $display("FAIL %s hi: got %h expected %h", name, got_hi, e[63:32]);
      end
      checks++;
      if (got_lo !== e[31:0]) begin
        errors++;
        $display("FAIL %s lo: got %h expected %h", name, got_lo, e[31:0]);
      end
    end
  endtask

  task automatic wait_done(input int lat, input string name);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== lat) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, lat);
    end
    check_regs(name);
  endtask

  task automatic run_expect(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                            input logic [63:0] e, input string name);
    m_hl = e;
    exp_q.push_back(e);
    drive_issue(o, x, y);
    wait_done(lat_of(o), name);
  endtask

  task automatic run_model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                           input string name);
    run_expect(o, x, y, model(o, x, y, m_hl), name);
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 4'hF;
    bus.a      = '0;
    bus.b      = '0;
    bus.use_md = 1'b1;
    bus.rd_sel = RD_SEL_LO;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset busy/stall: got %b/%b expected 0/0", bus.busy, bus.stall);
    end
    checks++;
    if (bus.dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset state: got %0d expected %0d", bus.dbg_state, ST_IDLE);
    end
    m_hl = '0;
    exp_q.push_back(64'd0);
    check_regs("reset");
    bus.use_md = 1'b0;
    reset      = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    run_expect(OP_MULT, 32'hFFFF_FFFD, 32'd4, 64'hFFFF_FFFF_FFFF_FFF4, "mult_neg3x4");
  endtask

  task automatic test_div();
    run_expect(OP_DIVU, 32'd7, 32'd2, {32'd1, 32'd3}, "divu_7_2");
    run_expect(OP_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_neg7_2");
  endtask

  task automatic test_div_zero();
    run_expect(OP_MTHI, 32'h55, 32'd0, {32'h55, m_hl[31:0]}, "mthi_55");
    run_expect(OP_MTLO, 32'h55, 32'd0, {32'h55, 32'h55}, "mtlo_55");
    run_expect(OP_DIV, 32'd9, 32'd0, {32'h55, 32'h55}, "div_by_zero");
  endtask

  task automatic test_stall();
    int n;
    bus.use_md = 1'b1;
    m_hl = {32'd0, 32'd42};
    exp_q.push_back(m_hl);
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.a     = 32'd6;
    bus.b     = 32'd7;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_issue: got %b expected 1", bus.stall);
    end
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      checks++;
      if (bus.stall !== 1'b1) begin
        errors++;
        $display("FAIL stall_busy cycle %0d: got %b expected 1", n, bus.stall);
      end
      if (n == 1) begin
        checks++;
        if (bus.dbg_state !== ST_BUSY) begin
          errors++;
          $display("FAIL busy_state: got %0d expected %0d", bus.dbg_state, ST_BUSY);
        end
      end
      // an mtlo and a second mult arrive mid-operation; both must be dropped
      if (n == 2) begin
        bus.start = 1'b1;
        bus.op    = OP_MTLO;
        bus.a     = 32'hDEAD_BEEF;
      end else if (n == 3) begin
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = 32'd100;
        bus.b     = 32'd100;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (n !== MLAT) begin
      errors++;
      $display("FAIL stall_busy_cycles: got %0d expected %0d", n, MLAT);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got %b expected 0", bus.stall);
    end
    bus.use_md = 1'b0;
    check_regs("stall_mult_6x7");
  endtask

  task automatic test_unknown();
    run_expect(4'hF, 32'h1234, 32'h5678, m_hl, "unknown_op");
  endtask

  task automatic test_back_to_back();
    run_expect(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "b2b_multu");
    run_expect(OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, "b2b_divu");
    run_expect(OP_DIV, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, "b2b_div");
    run_expect(OP_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "b2b_mult_min");
  endtask

  task automatic test_random();
    logic [3:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    for (int i = 0; i < 10; i++) begin
      o = 4'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if (i % 3 == 0) y = 32'($urandom_range(1, 20));
      if ((o == OP_DIV || o == OP_DIVU) && y == 0) y = 32'd1;
      if (o == OP_DIV && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) y = 32'd3;
      run_model(o, x, y, "random");
    end
  endtask

  task automatic test_reset_abort();
    drive_issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got %b expected 0", bus.busy);
    end
    exp_q.delete();
    m_hl = '0;
    exp_q.push_back(64'd0);
    check_regs("abort_regs");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_expect(OP_MTHI, 32'h12, 32'd0, {32'h12, 32'd0}, "abort_mthi");
  endtask

  task automatic test_madd();
    run_expect(OP_MTHI, 32'd0, 32'd0, {32'd0, m_hl[31:0]}, "madd_setup_hi");
    run_expect(OP_MTLO, 32'hFFFF_FFFF, 32'd0, {32'd0, 32'hFFFF_FFFF}, "madd_setup_lo");
`ifdef MDU_MADD_EN
    run_expect(OP_MADDU, 32'd1, 32'd1, {32'd1, 32'd0}, "maddu_1_1");
    run_expect(OP_MSUB, 32'd2, 32'd3, 64'h0000_0000_FFFF_FFFA, "msub_2_3");
    run_expect(OP_MADD, 32'hFFFF_FFFF, 32'd6, 64'h0000_0000_FFFF_FFF4, "madd_neg1_6");
`else
    run_expect(OP_MADDU, 32'd1, 32'd1, {32'd0, 32'hFFFF_FFFF}, "maddu_disabled");
    run_expect(OP_MSUB, 32'd2, 32'd3, {32'd0, 32'hFFFF_FFFF}, "msub_disabled");
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_stall();
    test_unknown();
    test_back_to_back();
    test_random();
    test_reset_abort();
    test_madd();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
